// File: rtl/spi_multi_master.sv
// rtl/spi_multi_master.sv - shared-bus SPI master (CPHA=0) with per-device chip selects and tail readback
module spi_multi_master #(
    parameter int   N_DEVICES   = 2,
    parameter int   P_SEL_WIDTH = 2,
    parameter int   P_WR_WIDTH  = 24,
    parameter int   P_RD_WIDTH  = 8,
    parameter int   P_SCLK_HALF = 30,
    parameter logic P_CPOL      = 1'b0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req,
    input  logic [P_SEL_WIDTH-1:0]             sel,
    input  logic [P_WR_WIDTH-1:0]              wr_data,
    input  logic [$clog2(P_WR_WIDTH+1)-1:0]    nb_wr,
    input  logic [$clog2(P_RD_WIDTH+1)-1:0]    nb_rd,
    output logic                               ack,
    output logic                               err,
    output logic                               busy,
    output logic [P_RD_WIDTH-1:0]              rd_data,
    output logic                               sclk,
    output logic                               mosi,
    output logic [N_DEVICES-1:0]               cs_n,
    input  logic [N_DEVICES-1:0]               miso
);
    localparam int NB_W = $clog2(P_WR_WIDTH + 1);
    localparam int HC_W = (P_SCLK_HALF > 1) ? $clog2(P_SCLK_HALF) : 1;
    localparam int SW1  = P_SEL_WIDTH + 1;
    localparam logic [NB_W-1:0] WR_MAX  = NB_W'(P_WR_WIDTH);
    localparam logic [NB_W-1:0] RD_MAX  = NB_W'(P_RD_WIDTH);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(P_SCLK_HALF - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP, ERR} state_t;

    state_t                 state, state_nxt;
    logic [HC_W-1:0]        hcnt, hcnt_nxt;
    logic [NB_W-1:0]        bitcnt, bitcnt_nxt, r_q, r_nxt;
    logic [NB_W-1:0]        n_eff, r_eff, n_m1, bit_prev;
    logic [P_SEL_WIDTH-1:0] sel_q, sel_nxt;
    logic [P_WR_WIDTH-1:0]  wr_q, wr_nxt;
    logic [P_RD_WIDTH-1:0]  rx, rx_nxt, rd_nxt;
    logic [N_DEVICES-1:0]   cs_nxt, cs_sel;
    logic                   sclk_nxt, mosi_nxt, ack_nxt, err_nxt, busy_nxt;
    logic                   half_done, miso_bit, sel_bad, do_sample;

    assign half_done = (hcnt == HC_LAST);
    assign sel_bad   = ({1'b0, sel} >= SW1'(N_DEVICES));
    assign n_m1      = n_eff - NB_W'(1);
    assign bit_prev  = bitcnt - NB_W'(1);

    // n = 0 means a full-width transfer; r never exceeds the register or the transfer
    always_comb begin
        n_eff = nb_wr;
        if (nb_wr == '0 || nb_wr > WR_MAX)
            n_eff = WR_MAX;
        r_eff = NB_W'(nb_rd);
        if (r_eff > RD_MAX)
            r_eff = RD_MAX;
        if (r_eff > n_eff)
            r_eff = n_eff;
    end

    always_comb begin
        cs_sel   = '1;
        miso_bit = 1'b0;
        for (int i = 0; i < N_DEVICES; i++) begin
            cs_sel[i] = (sel != P_SEL_WIDTH'(i));
            if (sel_q == P_SEL_WIDTH'(i))
                miso_bit = miso[i];
        end
    end

    always_comb begin
        state_nxt  = state;
        hcnt_nxt   = hcnt;
        bitcnt_nxt = bitcnt;
        r_nxt      = r_q;
        sel_nxt    = sel_q;
        wr_nxt     = wr_q;
        rx_nxt     = rx;
        rd_nxt     = rd_data;
        cs_nxt     = cs_n;
        sclk_nxt   = sclk;
        mosi_nxt   = mosi;
        ack_nxt    = 1'b0;
        err_nxt    = 1'b0;
        busy_nxt   = busy;
        do_sample  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    sel_nxt    = sel;
                    wr_nxt     = wr_data;
                    bitcnt_nxt = n_m1;
                    r_nxt      = r_eff;
                    rx_nxt     = '0;
                    hcnt_nxt   = '0;
                    busy_nxt   = 1'b1;
                    if (sel_bad) begin
                        state_nxt = ERR;
                        ack_nxt   = 1'b1;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = SETUP;
                        cs_nxt    = cs_sel;
                        mosi_nxt  = wr_data[n_m1];
                    end
                end
            end
            SETUP: begin
                if (half_done) begin
                    state_nxt = SHIFT;
                    hcnt_nxt  = '0;
                    sclk_nxt  = ~P_CPOL;
                    do_sample = 1'b1;
                end else begin
                    hcnt_nxt = hcnt + HC_W'(1);
                end
            end
            SHIFT: begin
                if (half_done) begin
                    hcnt_nxt = '0;
                    if (sclk != P_CPOL) begin
                        sclk_nxt = P_CPOL;
                        if (bitcnt == '0) begin
                            state_nxt = HOLD;
                            mosi_nxt  = 1'b0;
                        end else begin
                            bitcnt_nxt = bit_prev;
                            mosi_nxt   = wr_q[bit_prev];
                        end
                    end else begin
                        sclk_nxt  = ~P_CPOL;
                        do_sample = 1'b1;
                    end
                end else begin
                    hcnt_nxt = hcnt + HC_W'(1);
                end
            end
            HOLD: begin
                if (half_done) begin
                    state_nxt = GAP;
                    hcnt_nxt  = '0;
                    cs_nxt    = '1;
                    ack_nxt   = 1'b1;
                    rd_nxt    = rx;
                end else begin
                    hcnt_nxt = hcnt + HC_W'(1);
                end
            end
            // the ERR cycle is the first cycle of its own gap
            ERR, GAP: begin
                if (half_done) begin
                    state_nxt = IDLE;
                    hcnt_nxt  = '0;
                    busy_nxt  = 1'b0;
                end else begin
                    state_nxt = GAP;
                    hcnt_nxt  = hcnt + HC_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (do_sample && bitcnt < r_q) begin
            rx_nxt    = rx << 1;
            rx_nxt[0] = miso_bit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            hcnt    <= '0;
            bitcnt  <= '0;
            r_q     <= '0;
            sel_q   <= '0;
            wr_q    <= '0;
            rx      <= '0;
            rd_data <= '0;
            cs_n    <= '1;
            sclk    <= P_CPOL;
            mosi    <= 1'b0;
            ack     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            hcnt    <= hcnt_nxt;
            bitcnt  <= bitcnt_nxt;
            r_q     <= r_nxt;
            sel_q   <= sel_nxt;
            wr_q    <= wr_nxt;
            rx      <= rx_nxt;
            rd_data <= rd_nxt;
            cs_n    <= cs_nxt;
            sclk    <= sclk_nxt;
            mosi    <= mosi_nxt;
            ack     <= ack_nxt;
            err     <= err_nxt;
            busy    <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_spi_multi_master.sv
// tb/tb_spi_multi_master.sv - directed self-checking bench for spi_multi_master (H=2, CPOL 0 and 1)
module tb_spi_multi_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [1:0]  sel = '0;
    logic [23:0] wr_data = '0;
    logic [4:0]  nb_wr = '0;
    logic [3:0]  nb_rd = '0;
    logic [1:0]  miso;
    logic        ack0, err0, busy0, sclk0, mosi0, ack1, err1, busy1, sclk1, mosi1;
    logic [7:0]  rd_data0, rd_data1;
    logic [1:0]  cs_n0, cs_n1;

    int n_cmp = 0;
    int n_bad = 0;

    spi_multi_master #(.P_SCLK_HALF(2), .P_CPOL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .sel(sel), .wr_data(wr_data), .nb_wr(nb_wr), .nb_rd(nb_rd),
        .ack(ack0), .err(err0), .busy(busy0), .rd_data(rd_data0), .sclk(sclk0), .mosi(mosi0),
        .cs_n(cs_n0), .miso(miso));
    spi_multi_master #(.P_SCLK_HALF(2), .P_CPOL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .sel(sel), .wr_data(wr_data), .nb_wr(nb_wr), .nb_rd(nb_rd),
        .ack(ack1), .err(err1), .busy(busy1), .rd_data(rd_data1), .sclk(sclk1), .mosi(mosi1),
        .cs_n(cs_n1), .miso(miso));

    always #5 clk = ~clk;

    // device 0: 16-bit CPHA=0 slave shifting out 0x00A5, updates on trailing edges; device 1 drives 1
    logic [15:0] pat = 16'h00A5;
    int sidx = 15;
    always @(negedge sclk0 or posedge cs_n0[0]) begin
        if (cs_n0[0])
            sidx = 15;
        else if (sidx > 0)
            sidx = sidx - 1;
    end
    assign miso = {1'b1, pat[sidx[3:0]]};

    logic       dsel = 1'b0;
    logic       m_sclk, m_mosi, m_ack, m_err, m_busy;
    logic [1:0] m_cs;
    assign m_sclk = dsel ? sclk1 : sclk0;
    assign m_mosi = dsel ? mosi1 : mosi0;
    assign m_ack  = dsel ? ack1  : ack0;
    assign m_err  = dsel ? err1  : err0;
    assign m_busy = dsel ? busy1 : busy0;
    assign m_cs   = dsel ? cs_n1 : cs_n0;

    int          ack_cyc, busy_lo, lead_cnt, toggles;
    logic        err_at_ack, first_lvl;
    logic [23:0] mosi_word;
    logic [1:0]  cs_at1, cs_low_any;

    task automatic run_xfer(input logic d, input logic [1:0] s, input logic [23:0] w,
                            input logic [4:0] nw, input logic [3:0] nr, input int maxc);
        logic prev_sclk;
        dsel = d;
        ack_cyc = -1; busy_lo = -1; lead_cnt = 0; toggles = 0;
        err_at_ack = 1'b0; first_lvl = d; mosi_word = '0; cs_at1 = 2'b11; cs_low_any = 2'b00;
        @(negedge clk);
        sel = s; wr_data = w; nb_wr = nw; nb_rd = nr;
        if (d) req1 = 1'b1; else req0 = 1'b1;
        prev_sclk = m_sclk;
        @(posedge clk);
        #1;
        req0 = 1'b0; req1 = 1'b0;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            if (c == 1) cs_at1 = m_cs;
            cs_low_any = cs_low_any | ~m_cs;
            if (m_sclk !== prev_sclk) begin
                toggles++;
                if (toggles == 1) first_lvl = m_sclk;
                if (m_sclk !== d) begin
                    lead_cnt++;
                    mosi_word = {mosi_word[22:0], m_mosi};
                end
            end
            prev_sclk = m_sclk;
            if (m_ack === 1'b1 && ack_cyc < 0) begin
                ack_cyc = c;
                err_at_ack = m_err;
            end
            if (m_busy === 1'b0) begin
                busy_lo = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if ({cs_n0, sclk0, mosi0, ack0, err0, busy0} !== 7'b1100000) begin n_bad++;
            $display("FAIL reset_outputs0: got %b want 1100000", {cs_n0, sclk0, mosi0, ack0, err0, busy0}); end
        n_cmp++; if (rd_data0 !== 8'h00) begin n_bad++; $display("FAIL reset_rd0: got %h want 00", rd_data0); end
        n_cmp++; if ({cs_n1, sclk1, busy1} !== 4'b1110) begin n_bad++;
            $display("FAIL reset_outputs1: got %b want 1110", {cs_n1, sclk1, busy1}); end
    endtask

    task automatic test_write_only();
        run_xfer(1'b0, 2'd1, 24'h3A5F0C, 5'd24, 4'd0, 300);
        n_cmp++; if (cs_at1 !== 2'b01) begin n_bad++; $display("FAIL wo_cs: got %b want 01", cs_at1); end
        n_cmp++; if (mosi_word !== 24'h3A5F0C) begin n_bad++; $display("FAIL wo_mosi: got %h want 3a5f0c", mosi_word); end
        n_cmp++; if (lead_cnt !== 24) begin n_bad++; $display("FAIL wo_edges: got %0d want 24", lead_cnt); end
        n_cmp++; if (ack_cyc !== 99) begin n_bad++; $display("FAIL wo_ack_cycle: got %0d want 99", ack_cyc); end
        n_cmp++; if (busy_lo !== 101) begin n_bad++; $display("FAIL wo_busy_cycle: got %0d want 101", busy_lo); end
        n_cmp++; if (rd_data0 !== 8'h00) begin n_bad++; $display("FAIL wo_rd: got %h want 00", rd_data0); end
    endtask

    task automatic test_readback();
        run_xfer(1'b0, 2'd0, 24'h008100, 5'd16, 4'd8, 300);
        n_cmp++; if (rd_data0 !== 8'hA5) begin n_bad++; $display("FAIL rb_data: got %h want a5", rd_data0); end
        n_cmp++; if (mosi_word[15:0] !== 16'h8100) begin n_bad++; $display("FAIL rb_mosi: got %h want 8100", mosi_word[15:0]); end
        n_cmp++; if (ack_cyc !== 67) begin n_bad++; $display("FAIL rb_ack_cycle: got %0d want 67", ack_cyc); end
        n_cmp++; if (cs_low_any !== 2'b01) begin n_bad++; $display("FAIL rb_cs: got %b want 01", cs_low_any); end
        run_xfer(1'b0, 2'd1, 24'h00000A, 5'd4, 4'd3, 100);
        n_cmp++; if (rd_data0 !== 8'h07) begin n_bad++; $display("FAIL short_rd: got %h want 07", rd_data0); end
        n_cmp++; if (mosi_word[3:0] !== 4'hA) begin n_bad++; $display("FAIL short_mosi: got %h want a", mosi_word[3:0]); end
        n_cmp++; if (ack_cyc !== 19) begin n_bad++; $display("FAIL short_ack_cycle: got %0d want 19", ack_cyc); end
    endtask

    task automatic test_polarity_clamp();
        run_xfer(1'b1, 2'd1, 24'h123456, 5'd0, 4'd15, 300);
        n_cmp++; if (first_lvl !== 1'b0) begin n_bad++; $display("FAIL pol_first_edge: got %b want 0", first_lvl); end
        n_cmp++; if (lead_cnt !== 24) begin n_bad++; $display("FAIL pol_n_clamp: got %0d want 24", lead_cnt); end
        n_cmp++; if (mosi_word !== 24'h123456) begin n_bad++; $display("FAIL pol_mosi: got %h want 123456", mosi_word); end
        n_cmp++; if (ack_cyc !== 99) begin n_bad++; $display("FAIL pol_ack_cycle: got %0d want 99", ack_cyc); end
        n_cmp++; if (rd_data1 !== 8'hFF) begin n_bad++; $display("FAIL pol_r_clamp: got %h want ff", rd_data1); end
        n_cmp++; if (sclk1 !== 1'b1) begin n_bad++; $display("FAIL pol_idle: got %b want 1", sclk1); end
    endtask

    task automatic test_bad_select();
        run_xfer(1'b0, 2'd3, 24'hFFFFFF, 5'd8, 4'd8, 50);
        n_cmp++; if (ack_cyc !== 1) begin n_bad++; $display("FAIL bad_ack_cycle: got %0d want 1", ack_cyc); end
        n_cmp++; if (err_at_ack !== 1'b1) begin n_bad++; $display("FAIL bad_err: got %b want 1", err_at_ack); end
        n_cmp++; if (cs_low_any !== 2'b00) begin n_bad++; $display("FAIL bad_cs: got %b want 00", cs_low_any); end
        n_cmp++; if (toggles !== 0) begin n_bad++; $display("FAIL bad_sclk: got %0d toggles want 0", toggles); end
        n_cmp++; if (busy_lo !== 3) begin n_bad++; $display("FAIL bad_busy_cycle: got %0d want 3", busy_lo); end
        n_cmp++; if (rd_data0 !== 8'h07) begin n_bad++; $display("FAIL bad_rd_kept: got %h want 07", rd_data0); end
    endtask

    task automatic test_mid_reset();
        int acks;
        dsel = 1'b0;
        @(negedge clk);
        sel = 2'd0; wr_data = 24'hFFFFFF; nb_wr = 5'd24; nb_rd = 4'd0; req0 = 1'b1;
        @(posedge clk);
        #1 req0 = 1'b0;
        repeat (40) @(negedge clk);
        n_cmp++; if ({cs_n0, sclk0} !== 3'b101) begin n_bad++;
            $display("FAIL mr_pre: got %b want 101", {cs_n0, sclk0}); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({cs_n0, sclk0, ack0, busy0} !== 5'b11000) begin n_bad++;
            $display("FAIL mr_abort: got %b want 11000", {cs_n0, sclk0, ack0, busy0}); end
        n_cmp++; if (rd_data0 !== 8'h00) begin n_bad++; $display("FAIL mr_rd_clear: got %h want 00", rd_data0); end
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (ack0 === 1'b1 || cs_n0 !== 2'b11) acks++;
        end
        n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL mr_no_ack: got %0d cycles with ack/cs want 0", acks); end
        run_xfer(1'b0, 2'd1, 24'hC30F5A, 5'd24, 4'd8, 300);
        n_cmp++; if (mosi_word !== 24'hC30F5A) begin n_bad++; $display("FAIL mr_post_mosi: got %h want c30f5a", mosi_word); end
        n_cmp++; if (ack_cyc !== 99) begin n_bad++; $display("FAIL mr_post_ack: got %0d want 99", ack_cyc); end
        n_cmp++; if (rd_data0 !== 8'hFF) begin n_bad++; $display("FAIL mr_post_rd: got %h want ff", rd_data0); end
    endtask

    task automatic test_back_to_back();
        int   rise_c, fall_c, acks, ack2_c;
        logic prev_cs;
        dsel = 1'b0;
        rise_c = -1; fall_c = -1; acks = 0; ack2_c = -1;
        @(negedge clk);
        sel = 2'd0; wr_data = 24'h000005; nb_wr = 5'd4; nb_rd = 4'd0; req0 = 1'b1;
        prev_cs = cs_n0[0];
        @(posedge clk);
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (cs_n0[0] === 1'b1 && prev_cs === 1'b0 && rise_c < 0) rise_c = c;
            if (cs_n0[0] === 1'b0 && prev_cs === 1'b1 && rise_c >= 0 && fall_c < 0) fall_c = c;
            prev_cs = cs_n0[0];
            if (ack0 === 1'b1) begin
                acks++;
                if (acks == 2) ack2_c = c;
            end
            if (c == 23) req0 = 1'b0;
            if (c == 30) req0 = 1'b1;
            if (c == 31) req0 = 1'b0;
        end
        n_cmp++; if (rise_c !== 19) begin n_bad++; $display("FAIL b2b_cs_rise: got %0d want 19", rise_c); end
        n_cmp++; if (fall_c !== 22) begin n_bad++; $display("FAIL b2b_cs_fall: got %0d want 22", fall_c); end
        n_cmp++; if (acks !== 2) begin n_bad++; $display("FAIL b2b_ack_count: got %0d want 2", acks); end
        n_cmp++; if (ack2_c !== 40) begin n_bad++; $display("FAIL b2b_ack2_cycle: got %0d want 40", ack2_c); end
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL b2b_final_busy: got %b want 0", busy0); end
    endtask

    initial begin
        test_reset();
        test_write_only();
        test_readback();
        test_polarity_clamp();
        test_bad_select();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
